// File: rtl/bfp_pkg.sv
// ============================================================================
// Module  : bfp_pkg
// Brief   : Shared types and constants for the BFP block-delay scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bfp_pkg;

  localparam int BFP_SHIFT_W = 4;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_SHIFT = 2'd1,
    READY      = 2'd2,
    READING    = 2'd3
  } bank_state_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/bfp_bank_tracker.sv
// ============================================================================
// Module  : bfp_bank_tracker
// Brief   : State, length and shift of one ping-pong RAM bank.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfp_bank_tracker
  import bfp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int SHIFT_W = BFP_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_close,
  input  logic [ADDR_W:0]    i_len,
  input  logic               i_load_shift,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_rd_start,
  input  logic               i_rd_done,
  output bank_state_t        o_state,
  output logic [ADDR_W:0]    o_len,
  output logic [SHIFT_W-1:0] o_shift
);

  bank_state_t        r_state;
  logic [ADDR_W:0]    r_len;
  logic [SHIFT_W-1:0] r_shift;

  // Events are mutually exclusive per bank; done wins so a 1-sample block
  // can go READY -> FREE in the cycle it is both started and finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FREE;
      r_len   <= '0;
      r_shift <= '0;
    end else if (i_rd_done) begin
      r_state <= FREE;
    end else if (i_rd_start && (r_state == READY)) begin
      r_state <= READING;
    end else if (i_load_shift && (r_state == WAIT_SHIFT)) begin
      r_shift <= i_shift;
      r_state <= READY;
    end else if (i_close && (r_state == FREE)) begin
      r_len   <= i_len;
      r_state <= WAIT_SHIFT;
    end
  end

  assign o_state = r_state;
  assign o_len   = r_len;
  assign o_shift = r_shift;

endmodule

`default_nettype wire

// File: rtl/bfp_block_scheduler.sv
// ============================================================================
// Module  : bfp_block_scheduler
// Brief   : Ping-pong block-delay sequencer pairing each block with its shift.
//           Optional BFP_SCHED_STATS_EN adds blk_count / err_count outputs.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfp_block_scheduler
  import bfp_pkg::*;
#(
  parameter int MAX_BLOCK = 256,
  parameter int ADDR_W    = $clog2(MAX_BLOCK),
  parameter int SHIFT_W   = BFP_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [SHIFT_W-1:0] shift_in,
  input  logic               shift_valid,
  output logic               wr_en,
  output logic               wr_bank,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               rd_en,
  output logic               rd_bank,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               out_valid,
  output logic               out_last,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               ovf_err,
  output logic               shift_err
`ifdef BFP_SCHED_STATS_EN
  ,
  output logic [31:0]        blk_count,
  output logic [15:0]        err_count
`endif
);

  localparam logic [ADDR_W-1:0] c_blk_last = ADDR_W'(MAX_BLOCK - 1);
  localparam logic [ADDR_W:0]   c_one      = (ADDR_W + 1)'(1);

  logic               r_wr_ptr;
  logic               r_sh_ptr;
  logic               r_rd_ptr;
  logic [ADDR_W-1:0]  r_wr_cnt;
  logic [ADDR_W-1:0]  r_rd_cnt;
  rd_state_t          r_rd_state;
  logic               r_out_valid;
  logic               r_out_last;
  logic [SHIFT_W-1:0] r_out_shift;

  bank_state_t        w_st  [2];
  logic [ADDR_W:0]    w_len [2];
  logic [SHIFT_W-1:0] w_sh  [2];
  logic [1:0]         w_close_b;
  logic [1:0]         w_load_b;
  logic [1:0]         w_start_b;
  logic [1:0]         w_done_b;

  logic               w_accept;
  logic               w_close;
  logic [ADDR_W:0]    w_new_len;
  logic               w_sh_ok;
  logic               w_rd_fire;
  logic               w_rd_start;
  logic               w_rd_done;
  logic               w_other_ready;

  assign in_ready  = (w_st[r_wr_ptr] == FREE);
  assign w_accept  = in_valid && in_ready;
  assign w_close   = w_accept && (in_last || (r_wr_cnt == c_blk_last));
  assign w_new_len = {1'b0, r_wr_cnt} + c_one;
  assign w_sh_ok   = shift_valid && (w_st[r_sh_ptr] == WAIT_SHIFT);

  // The first read is issued in the cycle the bank turns READY, so the reader
  // never spends an extra cycle in IDLE before touching the RAM.
  assign w_rd_fire     = (r_rd_state == READ) || (w_st[r_rd_ptr] == READY);
  assign w_rd_start    = w_rd_fire && (w_st[r_rd_ptr] == READY);
  assign w_rd_done     = w_rd_fire && ({1'b0, r_rd_cnt} == (w_len[r_rd_ptr] - c_one));
  assign w_other_ready = (w_st[~r_rd_ptr] == READY);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_close_b[b] = w_close    && (r_wr_ptr == 1'(b));
    assign w_load_b[b]  = w_sh_ok    && (r_sh_ptr == 1'(b));
    assign w_start_b[b] = w_rd_start && (r_rd_ptr == 1'(b));
    assign w_done_b[b]  = w_rd_done  && (r_rd_ptr == 1'(b));

    bfp_bank_tracker #(
      .ADDR_W  (ADDR_W),
      .SHIFT_W (SHIFT_W)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .i_close      (w_close_b[b]),
      .i_len        (w_new_len),
      .i_load_shift (w_load_b[b]),
      .i_shift      (shift_in),
      .i_rd_start   (w_start_b[b]),
      .i_rd_done    (w_done_b[b]),
      .o_state      (w_st[b]),
      .o_len        (w_len[b]),
      .o_shift      (w_sh[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_wr_cnt <= '0;
      r_sh_ptr <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_wr_cnt <= '0;
          r_wr_ptr <= ~r_wr_ptr;
        end else begin
          r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
        end
      end
      if (w_sh_ok) begin
        r_sh_ptr <= ~r_sh_ptr;
      end
    end
  end

  // Read FSM; out_* are the read strobes delayed to line up with RAM dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state  <= IDLE;
      r_rd_ptr    <= 1'b0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_shift <= '0;
    end else begin
      r_out_valid <= w_rd_fire;
      r_out_last  <= w_rd_done;
      r_out_shift <= w_rd_fire ? w_sh[r_rd_ptr] : '0;
      if (w_rd_fire) begin
        if (w_rd_done) begin
          r_rd_cnt   <= '0;
          r_rd_ptr   <= ~r_rd_ptr;
          r_rd_state <= w_other_ready ? READ : IDLE;
        end else begin
          r_rd_cnt   <= r_rd_cnt + ADDR_W'(1);
          r_rd_state <= READ;
        end
      end
    end
  end

  assign wr_en     = w_accept;
  assign wr_bank   = w_accept && r_wr_ptr;
  assign wr_addr   = w_accept ? r_wr_cnt : '0;
  assign rd_en     = w_rd_fire;
  assign rd_bank   = w_rd_fire && r_rd_ptr;
  assign rd_addr   = w_rd_fire ? r_rd_cnt : '0;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_shift = r_out_shift;
  assign ovf_err   = w_close && !in_last;
  assign shift_err = shift_valid && !w_sh_ok;

`ifdef BFP_SCHED_STATS_EN
  logic [31:0] r_blk_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_rd_done) begin
        r_blk_count <= r_blk_count + 32'd1;
      end
      if ((ovf_err || shift_err) && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign blk_count = r_blk_count;
  assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: doc/bfp_block_scheduler.md
Name: bfp_block_scheduler

Overview:
- Sequences the block-delay buffer of the block-floating-point (BFP) normaliser.
- Uses a two-bank (ping-pong) sample RAM. Each bank holds one block, up to MAX_BLOCK samples.
- Writes incoming samples into the free bank and waits for the shift computed by bfp_calculator for that block. It then streams the block back out with its shift, so the downstream shifter always applies the exponent of the correct block.
- The RAM itself is external: a simple dual-port RAM with 1-cycle read latency.

Parameters:
- MAX_BLOCK, 256, maximum samples per block; also the depth of one RAM bank.
- ADDR_W, $clog2(MAX_BLOCK), width of the per-bank address.
- SHIFT_W, 4, width of the shift/exponent value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_last  in  1  marks the final sample of the block.
- in_ready  out  1  a bank is available for writing.
- shift_in  in  SHIFT_W  block shift from bfp_calculator.
- shift_valid  in  1  one-cycle strobe qualifying shift_in.
- wr_en  out  1  RAM write enable.
- wr_bank  out  1  RAM write bank select.
- wr_addr  out  ADDR_W  RAM write address.
- rd_en  out  1  RAM read enable.
- rd_bank  out  1  RAM read bank select.
- rd_addr  out  ADDR_W  RAM read address.
- out_valid  out  1  RAM read data valid this cycle.
- out_last  out  1  last sample of the outgoing block.
- out_shift  out  SHIFT_W  shift to apply to the current output sample.
- ovf_err  out  1  one-cycle pulse: block force-closed at MAX_BLOCK.
- shift_err  out  1  one-cycle pulse: shift_valid arrived with no bank waiting.

Behaviour:
- Per-bank state: FREE, WAIT_SHIFT, READY, READING.
- Per-bank registers: len (ADDR_W+1 bits) and shift (SHIFT_W bits).
- Reset, and the state forced by rst at any time including mid-block:
  - both banks FREE; all counters and pointers 0;
  - every output 0 (in_ready goes 1 on the first cycle after reset);
  - partially written or partially read data is discarded.
- Write side:
  - in_ready = (bank[wr_ptr] == FREE), decoded from registered state.
  - On accept (in_valid && in_ready): wr_en=1, wr_bank=wr_ptr, wr_addr=wr_cnt, combinationally in the same cycle; wr_cnt increments.
  - Block close condition: in_last, or wr_cnt == MAX_BLOCK-1.
  - On close: len = wr_cnt+1, bank -> WAIT_SHIFT, wr_cnt = 0, wr_ptr toggles.
  - A close without in_last pulses ovf_err; the following samples start a new block.
  - in_last on the first sample gives len = 1.
- Shift capture:
  - shift_valid loads shift_in into bank[sh_ptr] when that bank is WAIT_SHIFT; the bank -> READY and sh_ptr toggles.
  - Otherwise shift_valid is dropped and shift_err pulses.
  - shift_valid in the same cycle as the last-sample write of the bank it belongs to is an error, because the close takes effect at the clock edge.
- Read FSM, states IDLE and READ:
  - IDLE -> READ when bank[rd_ptr] == READY; that bank -> READING and rd_cnt = 0.
  - In READ, every cycle: rd_en=1, rd_bank=rd_ptr, rd_addr=rd_cnt, rd_cnt++.
  - When rd_cnt == len-1: the bank -> FREE and rd_ptr toggles.
  - If the other bank is already READY at that point, stay in READ with no bubble; otherwise go to IDLE.
- Output alignment:
  - out_valid, out_last and out_shift are rd_en, (rd_cnt == len-1) and bank shift, registered once, so they line up with RAM dout.
  - The output stream is non-stalling; the consumer must accept 1 sample/cycle.
- Simultaneous events:
  - A bank freed by the reader is writable from the next cycle (registered state).
  - A close and a shift capture on different banks in the same cycle both take effect.
  - A write and a read on different banks in the same cycle are legal.
- Latency: for a block whose shift arrives at cycle T, the first out_valid is at T+2 (READY at T+1, rd_en at T+1, data at T+2), provided the reader is idle.

Optional Feature:
- Macro: BFP_SCHED_STATS_EN.
- Defined: adds outputs blk_count[31:0] (increments on each block fully read out) and err_count[15:0] (increments on ovf_err or shift_err, saturating at 16'hFFFF). Both are cleared by rst.
- Undefined: the ports and logic are absent.

Decomposition:
- Package bfp_pkg holds:
  - typedef enum bank_state_t {FREE, WAIT_SHIFT, READY, READING};
  - typedef enum rd_state_t {IDLE, READ};
  - constant BFP_SHIFT_W = 4.
- One sub-module is natural: bfp_bank_tracker, which holds one bank's state, len and shift and is instantiated twice.
- The write/read pointers and the FSM stay in the top module.

Test Plan:
- Block of 8 samples, last on sample 8, shift_valid with 3 two cycles later -> wr_addr 0..7 on bank 0; rd_addr 0..7 on bank 0; out_valid for 8 cycles, out_shift=3, out_last on the 8th.
- Three back-to-back blocks of 4, shifts arriving late -> in_ready=0 while both banks are occupied; blocks emerge in order with shifts 1, 2, 3 and no bubble between READY banks.
- 256 samples with no in_last -> ovf_err pulses on sample 256; sample 257 is written to bank 1 at address 0.
- shift_valid with both banks FREE -> shift_err pulses; no state change.
- in_last on the first sample, shift 5 -> a single out_valid with out_last=1, out_shift=5.
- rst asserted mid-read of a 16-sample block -> next cycle all outputs 0, in_ready=1, no further out_valid.
